// File: rtl/host_uart_rx.sv
// host_uart_rx: 16x-oversampling UART receiver (8 data bits, optional even
// parity, 1 stop bit) feeding a show-ahead receive FIFO.
// FIFO handshake: rd_data is valid whenever empty=0; a byte is consumed at
// a rising edge where rd_en=1 and empty=0, and rd_en while empty is ignored.
module host_uart_rx #(
    parameter int BAUD_DIV  = 54,
    parameter int PARITY_EN = 0,
    parameter int FIFO_AW   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int DIV_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DIV_MAX = BAUD_DIV - 1;
    localparam int DEPTH   = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    state_t             r_state;
    logic [3:0]         r_tick_n;
    logic [2:0]         r_bit_n;
    logic [7:0]         r_shift;
    logic               r_par_err;
    logic               r_frame_err;
    logic               r_parity_err;
    logic               r_overrun;
    logic               w_mid16;
    logic               w_stop_smp;
    logic               w_push;
    logic               w_pop;
    logic               w_wr;
    logic               w_ovr;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    // Two-flop synchronizer on the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Free-running oversample divider; tick is high on its last count.
    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_tick     = (r_div == DIV_MAX[DIV_W-1:0]);
    assign w_mid16    = w_tick && (r_tick_n == 4'd15);
    assign w_stop_smp = (r_state == S_STOP) && w_mid16;
    assign w_push     = w_stop_smp && r_rx_s && !r_par_err;

    // Receive FSM: start qualification at mid start bit, then mid-bit samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick_n     <= 4'd0;
            r_bit_n      <= 3'd0;
            r_shift      <= 8'd0;
            r_par_err    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && !r_rx_s) begin
                        r_state   <= S_START;
                        r_tick_n  <= 4'd0;
                        r_bit_n   <= 3'd0;
                        r_par_err <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_n == 4'd7) begin
                            // A line that is high again by mid start bit was a glitch.
                            if (r_rx_s) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state  <= S_DATA;
                                r_tick_n <= 4'd0;
                            end
                        end else begin
                            r_tick_n <= r_tick_n + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_tick_n <= r_tick_n + 4'd1;
                        if (r_tick_n == 4'd15) begin
                            r_shift <= {r_rx_s, r_shift[7:1]};
                            r_bit_n <= r_bit_n + 3'd1;
                            if (r_bit_n == 3'd7) begin
                                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_tick_n <= r_tick_n + 4'd1;
                        if (r_tick_n == 4'd15) begin
                            // Even parity: the parity bit equals the XOR of the data bits.
                            r_par_err <= (r_rx_s != (^r_shift));
                            r_state   <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_tick_n <= r_tick_n + 4'd1;
                        if (r_tick_n == 4'd15) begin
                            if (r_rx_s) begin
                                r_parity_err <= r_par_err;
                                r_state      <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_WAIT_HIGH;
                            end
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // Hold off through a break so it reports only one framing error.
                    if (w_tick && r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop = rd_en && !empty;
    assign w_wr  = w_push && (!full || w_pop);
    assign w_ovr = w_push && full && !w_pop;

    // FIFO storage; the received byte is written on the stop-bit sample edge.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (w_wr) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data    = r_mem[r_rptr];
    assign empty      = (r_count == '0);
    assign full       = (r_count == DEPTH[FIFO_AW:0]);
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: doc/host_uart_rx.md
HOST_UART_RX -- requirements
Module: host_uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 54, meaning clocks per oversample tick (16 ticks per bit; 100 MHz / (115200*16)).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 = even parity bit expected after data bits.
REQ-003 SHALL have parameter FIFO_AW, default 3, meaning log2 of receive FIFO depth (8 entries).
REQ-004 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-006 SHALL have port rx, input, 1, meaning asynchronous serial line, idle high (driven by the core's Tx).
REQ-007 SHALL have port rd_en, input, 1, meaning pop FIFO head this cycle.
REQ-008 SHALL have port rd_data, output, 8, meaning FIFO head byte (show-ahead), valid while empty=0.
REQ-009 SHALL have port empty, output, 1, meaning FIFO holds no bytes.
REQ-010 SHALL have port full, output, 1, meaning FIFO holds 2^FIFO_AW bytes.
REQ-011 SHALL have port frame_err, output, 1, meaning one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port parity_err, output, 1, meaning one-cycle pulse: parity mismatch (PARITY_EN=1 only).
REQ-013 SHALL have port overrun, output, 1, meaning one-cycle pulse: good byte dropped because FIFO full.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (rx_s).
REQ-015 SHALL generate tick as a one-cycle pulse every BAUD_DIV clocks from a free-running counter, 0..BAUD_DIV-1, wrap to 0.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; reset state IDLE.
REQ-017 IDLE: on tick with rx_s=0 SHALL go to START with tick count cleared.
REQ-018 START: at 8th tick SHALL resample; rx_s=1 -> IDLE (glitch rejected, nothing reported); rx_s=0 -> DATA, count cleared.
REQ-019 DATA: SHALL sample rx_s every 16th tick (mid-bit), shift LSB first; after bit 7 go to PARITY if PARITY_EN else STOP.
REQ-020 PARITY: SHALL sample at 16th tick; mismatch with even parity of 8 data bits sets an internal error flag; go to STOP.
REQ-021 STOP: at 16th tick sample; rx_s=1 and no parity error -> push byte, IDLE; rx_s=1 with parity error -> parity_err pulse, no push, IDLE; rx_s=0 -> frame_err pulse, no push, WAIT_HIGH.
REQ-022 WAIT_HIGH: SHALL stay until rx_s=1 on a tick, then IDLE (break condition yields exactly one frame_err).
REQ-023 Error pulses and push SHALL occur in the same clock as the deciding stop-bit sample.
REQ-024 FIFO: circular buffer, FIFO_AW-bit pointers plus count of width FIFO_AW+1; empty = (count==0), full = (count==2^FIFO_AW).
REQ-025 Pop SHALL occur on rd_en && !empty; rd_en while empty SHALL be ignored, no state change.
REQ-026 Push while full without same-cycle pop SHALL drop the byte and pulse overrun; FIFO contents unchanged.
REQ-027 Push and pop in the same cycle SHALL both succeed (including when full); count unchanged.
REQ-028 rd_data SHALL equal the head entry combinationally from the read pointer; pushed byte visible the cycle after push.
REQ-029 Latency: byte available (empty=0) one clock after the stop-bit mid-sample.

Reset
REQ-030 On rst=1 at a clock edge SHALL: state IDLE, tick counter 0, bit counters 0, pointers and count 0, empty=1, full=0, frame_err=parity_err=overrun=0, synchronizer flops 1.
REQ-031 Reset mid-frame SHALL abandon the partial byte; following frame received normally once rx returns high then falls.

Verification
REQ-032 BAUD_DIV=4, PARITY_EN=0: send 0xA5 (8N1, 64 clk/bit) -> empty falls after stop mid-sample, rd_data=0xA5, no error pulses.
REQ-033 rx low pulse of 16 clocks in IDLE -> START rejects it, FIFO stays empty, no error pulses.
REQ-034 Frame 0x3C with stop bit 0 held low 3 bit times -> exactly one frame_err pulse, FIFO empty, next 0x3C received.
REQ-035 PARITY_EN=1: send 0x07 with parity bit 0 -> one parity_err pulse, nothing pushed; with parity 1 -> 0x07 pushed.
REQ-036 Send 9 bytes 0x00..0x08 with no reads -> full=1 after 8th, overrun pulse on 9th; reads return 0x00..0x07 then empty=1.
REQ-037 Assert rst during DATA bit 4 of 0xFF, then send 0x5A -> only 0x5A in FIFO.
